regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
- Parametrised successor to the single-issue 32x32 integer register file in the RISC-V datapath.
- Provides NUM_READ asynchronous read ports, one synchronous write port, optional same-cycle write-to-read bypass, hardwired x0, and synchronous clearing of all registers on reset.
- Adds a per-register pending scoreboard so the decode stage can stall on in-flight writes (e.g. loads).
- Sits between decode (reads, issue) and writeback (write).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NUM_READ, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is visible on matching read ports; 0 = the read returns the old value.
- AW, $clog2(NREGS), address width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- readAddr  in  NUM_READ*AW  packed read addresses; port i occupies [i*AW +: AW].
- readData  out  NUM_READ*XLEN  packed read data; port i occupies [i*XLEN +: XLEN].
- readBusy  out  NUM_READ  port i: its register is pending and not being resolved this cycle.
- regWrite  in  1  write enable.
- writeRegister  in  AW  write address.
- writeData  in  XLEN  write data.
- issueEn  in  1  mark issueRegister as pending.
- issueRegister  in  AW  destination register of the issuing instruction.

Behaviour:
- Reset (rst_n=0 at posedge):
  - all NREGS registers become 0;
  - all pending bits become 0;
  - regWrite and issueEn in that cycle are ignored.
  - Reset in the cycle after an issue still clears that pending bit.
- Register 0:
  - always reads 0 and is never marked pending;
  - writes to address 0 are dropped;
  - readBusy for address 0 is always 0;
  - no bypass applies to address 0.
- Read path:
  - purely combinational; zero latency from readAddr to readData/readBusy;
  - all ports are independent and may alias the same address.
- Write:
  - at posedge, if rst_n=1, regWrite=1 and writeRegister!=0, mem[writeRegister] <= writeData;
  - the write clears pending[writeRegister].
- Bypass (BYPASS=1):
  - if regWrite=1, writeRegister==readAddr_i and the address is !=0, then readData_i=writeData and readBusy_i=0 in the same cycle.
- No bypass (BYPASS=0):
  - readData_i is the stored value;
  - readBusy_i reflects the pending bit before the clock edge.
- Issue:
  - at posedge, if issueEn=1 and issueRegister!=0, pending[issueRegister] <= 1.
- Simultaneous write and issue to the same register: set wins, so pending stays 1 and the data is still written. This models back-to-back writers to one register.
- Simultaneous write and issue to different registers: both take effect independently.
- readBusy_i = pending[readAddr_i] AND NOT bypass-hit_i, where bypass-hit_i is forced 0 when BYPASS=0.
- Out-of-range address (NREGS not a power of two is disallowed): the assertion checks NREGS == 2**AW at elaboration.
- No back-pressure: a write to a non-pending register is legal and simply stores the value.

Decomposition:
- Package regfile_pkg holds:
  - ZERO_REG = 0;
  - default XLEN/NREGS constants;
  - helper function readSlice(packed, idx) for port indexing.
- Sub-module regfile_scoreboard (NREGS pending bits, set/clear/reset logic, x0 masking) instantiated once.
- Data array and read muxes stay in the top module, generated over NUM_READ.

Test Plan:
- Reset then read: after rst_n=0 for 1 cycle, every address on both ports gives readData=0 and readBusy=0.
- Write/readback: write 0xDEADBEEF to x5, then next cycle readAddr0=5 gives 0xDEADBEEF; write 0x1234 to x0, then reading x0 gives 0.
- Bypass:
  - BYPASS=1: same cycle regWrite x7=0xA5A5A5A5 with readAddr1=7 gives readData1=0xA5A5A5A5 immediately.
  - BYPASS=0: the same stimulus gives the old value (0) that cycle and the new value next cycle.
- Scoreboard: issue x10, then next cycle readBusy for x10 is 1; write x10=0x42, then in that cycle readBusy=0 (BYPASS=1) and in the following cycle readBusy=0 with data 0x42.
- Set-wins collision: issue x3 and write x3=0x99 in the same cycle, then next cycle x3 reads 0x99 with readBusy=1. An issue of x0 never sets busy.
- Reset mid-operation: issue x12, write x4=0x55, assert rst_n=0 for 1 cycle, then x4 reads 0 and x12 has readBusy=0. Repeat with NUM_READ=4, XLEN=64, NREGS=16, with all ports aliasing x15.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Imported by the scoreboard and the register file top.
package regfile_pkg;

  localparam int ZERO_REG    = 0;
  localparam int DEF_XLEN    = 32;
  localparam int DEF_NREGS   = 32;
  localparam int SLICE_BUS_W = 64;

  // Extract field idx (width w) from a packed port bus.
  function automatic logic [15:0] readSlice(
    input logic [SLICE_BUS_W-1:0] bus,
    input int                     idx,
    input int                     w
  );
    readSlice = 16'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for in-flight destination writes.
// Set on issue, cleared on writeback, x0 never pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [AW-1:0]    set_idx,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_idx,
  output logic [NREGS-1:0] pending
);

  logic [NREGS-1:0] pending_nxt;

  // Next pending vector: clear first so a same-register set wins.
  always_comb begin
    pending_nxt = pending;
    if (clr_en)
      pending_nxt[clr_idx] = 1'b0;
    if (set_en)
      pending_nxt[set_idx] = 1'b1;
    pending_nxt[ZERO_REG] = 1'b0;
  end

  // Pending register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port integer register file with write bypass
// and a pending scoreboard for decode-stage stalls.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int XLEN     = DEF_XLEN,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int NUM_READ = 2,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_READ*AW-1:0]   readAddr,
  output logic [NUM_READ*XLEN-1:0] readData,
  output logic [NUM_READ-1:0]      readBusy,
  input  logic                     regWrite,
  input  logic [AW-1:0]            writeRegister,
  input  logic [XLEN-1:0]          writeData,
  input  logic                     issueEn,
  input  logic [AW-1:0]            issueRegister
);

  if (NREGS != (1 << AW)) begin : g_bad_nregs
    $error("regfile_multiport: NREGS must be a power of two");
  end
  if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_ports
    $error("regfile_multiport: NUM_READ must be 1..4");
  end

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] pending;
  logic             wr_ok;
  logic             iss_ok;

  assign wr_ok  = regWrite && (writeRegister != AW'(ZERO_REG));
  assign iss_ok = issueEn && (issueRegister != AW'(ZERO_REG));

  regfile_scoreboard #(
    .NREGS(NREGS),
    .AW   (AW)
  ) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_en (iss_ok),
    .set_idx(issueRegister),
    .clr_en (wr_ok),
    .clr_idx(writeRegister),
    .pending(pending)
  );

  // Data array: clear everything on reset, else write one register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        mem[r] <= '0;
    end else if (wr_ok) begin
      mem[writeRegister] <= writeData;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0]   raddr;
    logic            nz;
    logic            hit;
    logic [XLEN-1:0] rdata;

    assign raddr = AW'(readSlice(SLICE_BUS_W'(readAddr), i, AW));
    assign nz    = (raddr != AW'(ZERO_REG));

    // Combinational read with optional same-cycle write forwarding.
    always_comb begin
      hit   = (BYPASS != 0) && wr_ok && (writeRegister == raddr);
      rdata = '0;
      if (nz)
        rdata = hit ? writeData : mem[raddr];
    end

    assign readData[i*XLEN +: XLEN] = rdata;
    assign readBusy[i] = nz && pending[raddr] && !hit;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: bypass, no-bypass and
// a 4-port 64-bit 16-register build against an array model.
module tb_regfile_multiport;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0]  abRa;
  logic [63:0] aRd, bRd;
  logic [1:0]  aBusy, bBusy;
  logic        abWe, abIe;
  logic [4:0]  abWa, abIr;
  logic [31:0] abWd;

  logic [15:0]  cRa;
  logic [255:0] cRd;
  logic [3:0]   cBusy;
  logic         cWe, cIe;
  logic [3:0]   cWa, cIr;
  logic [63:0]  cWd;

  regfile_multiport #(.BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .readAddr(abRa), .readData(aRd), .readBusy(aBusy),
    .regWrite(abWe), .writeRegister(abWa), .writeData(abWd),
    .issueEn(abIe), .issueRegister(abIr)
  );

  regfile_multiport #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .readAddr(abRa), .readData(bRd), .readBusy(bBusy),
    .regWrite(abWe), .writeRegister(abWa), .writeData(abWd),
    .issueEn(abIe), .issueRegister(abIr)
  );

  regfile_multiport #(
    .XLEN(64), .NREGS(16), .NUM_READ(4), .BYPASS(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n),
    .readAddr(cRa), .readData(cRd), .readBusy(cBusy),
    .regWrite(cWe), .writeRegister(cWa), .writeData(cWd),
    .issueEn(cIe), .issueRegister(cIr)
  );

  // Architectural model: register contents and in-flight flags.
  logic [31:0] mAB [32];
  bit          pAB [32];
  logic [63:0] mC  [16];
  bit          pC  [16];

  int checks = 0;
  int failures = 0;

  task automatic cmp(string tag, int port,
                     logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s port%0d got=%h exp=%h", tag, port, got, exp);
    end
  endtask

  task automatic idle();
    abWe = 0; abIe = 0; abWa = 0; abIr = 0; abWd = 0;
    cWe = 0; cIe = 0; cWa = 0; cIr = 0; cWd = 0;
  endtask

  // Expected view of one port, straight from the architectural rules.
  task automatic chk();
    int a;
    bit hit;
    logic [63:0] ed;
    #1;
    for (int i = 0; i < 2; i++) begin
      a = int'(abRa[i*5 +: 5]);
      hit = abWe && (int'(abWa) == a) && (a != 0);
      ed  = (a == 0) ? 64'd0 : (hit ? 64'(abWd) : 64'(mAB[a]));
      cmp("A_data", i, 64'(aRd[i*32 +: 32]), ed);
      cmp("A_busy", i, 64'(aBusy[i]),
          64'((a != 0) && pAB[a] && !hit));
      ed = (a == 0) ? 64'd0 : 64'(mAB[a]);
      cmp("B_data", i, 64'(bRd[i*32 +: 32]), ed);
      cmp("B_busy", i, 64'(bBusy[i]), 64'((a != 0) && pAB[a]));
    end
    for (int i = 0; i < 4; i++) begin
      a = int'(cRa[i*4 +: 4]);
      hit = cWe && (int'(cWa) == a) && (a != 0);
      ed  = (a == 0) ? 64'd0 : (hit ? cWd : mC[a]);
      cmp("C_data", i, cRd[i*64 +: 64], ed);
      cmp("C_busy", i, 64'(cBusy[i]),
          64'((a != 0) && pC[a] && !hit));
    end
  endtask

  // Advance one clock, applying the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin mAB[r] = 0; pAB[r] = 0; end
      for (int r = 0; r < 16; r++) begin mC[r] = 0; pC[r] = 0; end
    end else begin
      if (abWe && abWa != 0) begin
        mAB[abWa] = abWd; pAB[abWa] = 0;
      end
      if (abIe && abIr != 0) pAB[abIr] = 1;
      if (cWe && cWa != 0) begin
        mC[cWa] = cWd; pC[cWa] = 0;
      end
      if (cIe && cIr != 0) pC[cIr] = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; idle(); abRa = 0; cRa = 0;
    @(negedge clk);
    tick();
    rst_n = 1;

    // every address reads zero and not busy after reset
    for (int a = 0; a < 32; a++) begin
      abRa = {5'(a), 5'(a)};
      cRa  = {4{4'(a % 16)}};
      chk(); tick();
    end

    // write and read back; write to x0 dropped
    abWe = 1; abWa = 5; abWd = 32'hDEADBEEF;
    cWe = 1; cWa = 5; cWd = 64'hDEADBEEF_CAFEF00D;
    abRa = 0; cRa = 0;
    chk(); tick(); idle();
    abRa = {5'd0, 5'd5}; cRa = {4'd0, 4'd0, 4'd0, 4'd5};
    chk();
    abWe = 1; abWa = 0; abWd = 32'h1234;
    cWe = 1; cWa = 0; cWd = 64'h1234;
    abRa = 0; cRa = 0;
    chk(); tick(); idle(); chk();

    // same-cycle bypass vs stored value
    abWe = 1; abWa = 7; abWd = 32'hA5A5A5A5;
    cWe = 1; cWa = 7; cWd = 64'hA5A5A5A5_5A5A5A5A;
    abRa = {5'd7, 5'd0}; cRa = {4'd0, 4'd0, 4'd7, 4'd0};
    chk(); tick(); idle(); chk();

    // scoreboard: issue then resolve
    abIe = 1; abIr = 10; cIe = 1; cIr = 10;
    tick(); idle();
    abRa = {5'd10, 5'd10}; cRa = {4{4'd10}};
    chk();
    abWe = 1; abWa = 10; abWd = 32'h42;
    cWe = 1; cWa = 10; cWd = 64'h42;
    chk(); tick(); idle(); chk();

    // set wins on collision; x0 never pending
    abIe = 1; abIr = 3; abWe = 1; abWa = 3; abWd = 32'h99;
    cIe = 1; cIr = 3; cWe = 1; cWa = 3; cWd = 64'h99;
    tick(); idle();
    abRa = {5'd3, 5'd3}; cRa = {4{4'd3}};
    chk();
    abIe = 1; abIr = 0; cIe = 1; cIr = 0;
    tick(); idle();
    abRa = 0; cRa = 0;
    chk();

    // reset mid-operation, C ports all aliasing x15
    abIe = 1; abIr = 12; abWe = 1; abWa = 4; abWd = 32'h55;
    cIe = 1; cIr = 15; cWe = 1; cWa = 4; cWd = 64'h55;
    tick(); idle();
    abRa = {5'd12, 5'd4}; cRa = {4{4'd15}};
    chk();
    rst_n = 0;
    abWe = 1; abWa = 9; abWd = 32'h77; cIe = 1; cIr = 9;
    tick(); idle(); rst_n = 1;
    chk();
    abRa = {5'd9, 5'd9}; cRa = {4{4'd9}};
    chk();
    cIe = 1; cIr = 15; tick(); idle();
    cRa = {4{4'd15}};
    cWe = 1; cWa = 15; cWd = 64'h0123_4567_89AB_CDEF;
    chk(); tick(); idle(); chk();

    // randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      abRa = 10'($urandom);
      abWe = 1'($urandom); abWa = 5'($urandom); abWd = $urandom;
      abIe = 1'($urandom); abIr = 5'($urandom);
      cRa = 16'($urandom);
      cWe = 1'($urandom); cWa = 4'($urandom);
      cWd = {$urandom, $urandom};
      cIe = 1'($urandom); cIr = 4'($urandom);
      chk(); tick();
    end
    rst_n = 1; idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
